// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU ops, wakes pending operands
// from the three CDB ports, and issues ready ops in order of entry index
// through a registered valid/ready stage.
module alu_reservation_station #(
  parameter int unsigned RS_DEPTH = 4,
  parameter int unsigned ROB_W    = 3,
  parameter int unsigned OP_W     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              disp_valid,
  output logic                              disp_ready,
  input  logic [OP_W-1:0]                   disp_aluop,
  input  logic [31:0]                       disp_opA_value,
  input  logic [ROB_W-1:0]                  disp_opA_tag,
  input  logic [31:0]                       disp_opB_value,
  input  logic [ROB_W-1:0]                  disp_opB_tag,
  input  logic [ROB_W-1:0]                  disp_dest,
  input  logic [ROB_W-1:0]                  CDB_ALU_ROB_index,
  input  logic [31:0]                       CDB_ALU_data,
  input  logic [ROB_W-1:0]                  CDB_LSQ_ROB_index,
  input  logic [31:0]                       CDB_LSQ_data,
  input  logic [ROB_W-1:0]                  CDB_BRA_ROB_index,
  input  logic [31:0]                       CDB_BRA_data,
  output logic                              iss_valid,
  input  logic                              iss_ready,
  output logic [OP_W-1:0]                   iss_aluop,
  output logic [31:0]                       iss_opA,
  output logic [31:0]                       iss_opB,
  output logic [ROB_W-1:0]                  iss_dest,
  output logic [$clog2(RS_DEPTH+1)-1:0]     occupancy
);

  localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);
  localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  // Entry storage
  logic [RS_DEPTH-1:0] ent_valid;
  logic [OP_W-1:0]     ent_aluop [RS_DEPTH];
  logic [31:0]         ent_a_val [RS_DEPTH];
  logic [ROB_W-1:0]    ent_a_tag [RS_DEPTH];
  logic [31:0]         ent_b_val [RS_DEPTH];
  logic [ROB_W-1:0]    ent_b_tag [RS_DEPTH];
  logic [ROB_W-1:0]    ent_dest  [RS_DEPTH];

  // Wakeup results per entry/operand
  logic [RS_DEPTH-1:0] a_wake;
  logic [RS_DEPTH-1:0] b_wake;
  logic [31:0]         a_wdata [RS_DEPTH];
  logic [31:0]         b_wdata [RS_DEPTH];

  // Selection and next-state helpers
  logic [RS_DEPTH-1:0] ent_ready;
  logic                disp_hit;
  logic [IDX_W-1:0]    disp_idx;
  logic                rdy_any;
  logic [IDX_W-1:0]    sel_idx;
  logic                load_en;
  logic                disp_fire;
  logic                issue_fire;
  logic [RS_DEPTH-1:0] valid_nxt;
  logic [CNT_W-1:0]    cnt_nxt;

  // CDB match for one pending tag; ALU wins over LSQ, LSQ over BRA.
  function automatic logic [32:0] cdb_snoop(
    input logic [ROB_W-1:0] tag,
    input logic [ROB_W-1:0] alu_idx,
    input logic [31:0]      alu_data,
    input logic [ROB_W-1:0] lsq_idx,
    input logic [31:0]      lsq_data,
    input logic [ROB_W-1:0] bra_idx,
    input logic [31:0]      bra_data
  );
    logic [32:0] res;
    res = '0;
    if (tag != '0) begin
      if (alu_idx == tag)      res = {1'b1, alu_data};
      else if (lsq_idx == tag) res = {1'b1, lsq_data};
      else if (bra_idx == tag) res = {1'b1, bra_data};
    end
    return res;
  endfunction

  // Operand wakeup for every valid entry with a pending tag
  always_comb begin
    logic [32:0] sa;
    logic [32:0] sb;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      sa = cdb_snoop(ent_a_tag[i], CDB_ALU_ROB_index, CDB_ALU_data,
                     CDB_LSQ_ROB_index, CDB_LSQ_data,
                     CDB_BRA_ROB_index, CDB_BRA_data);
      sb = cdb_snoop(ent_b_tag[i], CDB_ALU_ROB_index, CDB_ALU_data,
                     CDB_LSQ_ROB_index, CDB_LSQ_data,
                     CDB_BRA_ROB_index, CDB_BRA_data);
      a_wake[i]  = ent_valid[i] && sa[32];
      b_wake[i]  = ent_valid[i] && sb[32];
      a_wdata[i] = sa[31:0];
      b_wdata[i] = sb[31:0];
    end
  end

  // Lowest free entry for dispatch and lowest ready entry for issue
  always_comb begin
    disp_hit = 1'b0;
    disp_idx = '0;
    rdy_any  = 1'b0;
    sel_idx  = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      ent_ready[i] = ent_valid[i] && (ent_a_tag[i] == '0) && (ent_b_tag[i] == '0);
      if (!disp_hit && !ent_valid[i]) begin
        disp_hit = 1'b1;
        disp_idx = IDX_W'(i);
      end
      if (!rdy_any && ent_ready[i]) begin
        rdy_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Handshake decisions and next valid vector / occupancy
  always_comb begin
    load_en    = !iss_valid || iss_ready;
    issue_fire = load_en && rdy_any;
    disp_fire  = disp_valid && disp_ready && disp_hit;
    valid_nxt  = ent_valid;
    if (issue_fire) valid_nxt[sel_idx] = 1'b0;
    if (disp_fire)  valid_nxt[disp_idx] = 1'b1;
    if (flush)      valid_nxt = '0;
    cnt_nxt = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(valid_nxt[i]);
    end
  end

  // Entry valid bits, occupancy and dispatch availability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid  <= '0;
      occupancy  <= '0;
      disp_ready <= 1'b1;
    end else begin
      ent_valid  <= valid_nxt;
      occupancy  <= cnt_nxt;
      disp_ready <= !(&valid_nxt);
    end
  end

  // Entry payload: dispatch write, otherwise independent A/B capture from CDB
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (disp_fire && (disp_idx == IDX_W'(i))) begin
        ent_aluop[i] <= disp_aluop;
        ent_a_val[i] <= disp_opA_value;
        ent_a_tag[i] <= disp_opA_tag;
        ent_b_val[i] <= disp_opB_value;
        ent_b_tag[i] <= disp_opB_tag;
        ent_dest[i]  <= disp_dest;
      end else begin
        if (a_wake[i]) begin
          ent_a_val[i] <= a_wdata[i];
          ent_a_tag[i] <= '0;
        end
        if (b_wake[i]) begin
          ent_b_val[i] <= b_wdata[i];
          ent_b_tag[i] <= '0;
        end
      end
    end
  end

  // Issue register: loads when empty or drained, holds on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_aluop <= '0;
      iss_opA   <= '0;
      iss_opB   <= '0;
      iss_dest  <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (load_en) begin
      if (rdy_any) begin
        iss_valid <= 1'b1;
        iss_aluop <= ent_aluop[sel_idx];
        iss_opA   <= ent_a_val[sel_idx];
        iss_opB   <= ent_b_val[sel_idx];
        iss_dest  <= ent_dest[sel_idx];
      end else begin
        iss_valid <= 1'b0;
      end
    end
  end

endmodule
